// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch controller and its
//   neighbour inst_mgmt: inst_sel codes, the NOP instruction word, the
//   fetch FSM state type and small PC helpers.
package fetch_ctrl_pkg;

    // inst_sel codes seen by inst_mgmt (2'b11 is reserved and never driven)
    localparam logic [1:0] INST_MEM = 2'd0;  // forward memory rdata
    localparam logic [1:0] INST_OLD = 2'd1;  // hold the previously forwarded word
    localparam logic [1:0] INST_NOP = 2'd2;  // squash, inst_mgmt injects NOP_INSTR

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^32 with no overflow indication.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced word-aligned.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch controller in front of inst_mgmt. Owns the PC, drives
//   the address of a synchronous instruction memory (1-cycle read latency),
//   tracks which PC the returned rdata belongs to and tells inst_mgmt whether
//   to forward (MEM), hold (OLD) or squash (NOP) the fetched word.
//
// Ports
//   clk            in   core clock, rising edge
//   rst            in   asynchronous active-low reset
//   stall          in   hazard hold request from decode/execute
//   branch_taken   in   redirect request
//   branch_target  in   redirect address [31:0] (low two bits dropped)
//   fetch_addr     out  instruction memory address [31:0] (combinational)
//   pc_id          out  PC of the word currently on memory rdata [31:0]
//   inst_sel       out  selector for inst_mgmt [1:0] (combinational)
//   flushing       out  high while the FSM is in FLUSH
//   dbg_state      out  current FSM state, for debug/checkers
//
// Handshake: there is no valid/ready pair. Every cycle inst_sel qualifies
// the word on rdata: MEM = rdata is mem[pc_id] and is consumed this cycle,
// OLD = consumer must keep its previous word, NOP = consumer inserts a NOP.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,  // bits [1:0] must be 0
    parameter int          FLUSH_CYCLES = 2               // legal range 1..7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic [31:0]  fetch_addr,
    output logic [31:0]  pc_id,
    output logic [1:0]   inst_sel,
    output logic         flushing,
    output fetch_state_t dbg_state
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pc_id;
    logic [2:0]   r_flush_cnt;

    logic [31:0]  w_target;
    logic [31:0]  w_pc_inc;
    logic         w_unused_target_lsbs;

    assign w_target             = pc_align(branch_target);
    assign w_pc_inc             = pc_next(r_pc);
    assign w_unused_target_lsbs = ^branch_target[1:0];

    // State and PC registers. pc_id always trails the address presented one
    // cycle earlier, except while stalled where both freeze and the memory is
    // re-read at pc_id so rdata keeps showing the held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH_BOOT;
            r_pc        <= RESET_PC;
            r_pc_id     <= RESET_PC;
            r_flush_cnt <= 3'd0;
        end else begin
            case (r_state)
                FETCH_BOOT: begin
                    // stall and branch_taken are ignored while booting
                    r_pc    <= w_pc_inc;
                    r_pc_id <= r_pc;
                    r_state <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (branch_taken) begin
                        r_pc        <= w_target;
                        r_pc_id     <= r_pc;
                        r_flush_cnt <= FLUSH_LOAD;
                        r_state     <= FETCH_FLUSH;
                    end else if (!stall) begin
                        r_pc    <= w_pc_inc;
                        r_pc_id <= r_pc;
                    end
                end
                FETCH_FLUSH: begin
                    // A new redirect restarts the flush; stall has no effect.
                    if (branch_taken) begin
                        r_pc        <= w_target;
                        r_pc_id     <= r_pc;
                        r_flush_cnt <= FLUSH_LOAD;
                    end else if (r_flush_cnt != 3'd0) begin
                        r_pc_id     <= r_pc;
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end else begin
                        // rdata now holds mem[target]; it is forwarded next cycle
                        r_pc    <= w_pc_inc;
                        r_pc_id <= r_pc;
                        r_state <= FETCH_RUN;
                    end
                end
                default: begin
                    r_state <= FETCH_BOOT;
                end
            endcase
        end
    end

    // Output decode; branch_taken outranks stall in RUN.
    always_comb begin
        fetch_addr = r_pc;
        inst_sel   = INST_NOP;
        case (r_state)
            FETCH_RUN: begin
                if (branch_taken) begin
                    inst_sel = INST_NOP;
                end else if (stall) begin
                    fetch_addr = r_pc_id;
                    inst_sel   = INST_OLD;
                end else begin
                    inst_sel = INST_MEM;
                end
            end
            default: begin
                fetch_addr = r_pc;
                inst_sel   = INST_NOP;
            end
        endcase
    end

    assign pc_id     = r_pc_id;
    assign flushing  = (r_state == FETCH_FLUSH);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Bench for fetch_ctrl: directed vector table for boot/stall/branch/wrap,
//   a hand-written async-reset-during-flush sequence, then random stimulus
//   against a cycle-level reference model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FLUSH_N = 2;
  localparam int          NVEC = 24;
  localparam int          NRAND = 400;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_target = 32'h0;
  logic [31:0]  fetch_addr;
  logic [31:0]  pc_id;
  logic [1:0]   inst_sel;
  logic         flushing;
  fetch_state_t dbg_state;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .fetch_addr(fetch_addr),
    .pc_id(pc_id),
    .inst_sel(inst_sel),
    .flushing(flushing),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the next sequential fetch address, the PC whose word is on rdata,
  // whether the boot cycle is pending and how many squash cycles remain.
  logic [31:0] m_pc, m_pc_id;
  bit          m_boot;
  int          m_flush_left;

  task automatic model_reset();
    m_pc = RST_PC; m_pc_id = RST_PC; m_boot = 1'b1; m_flush_left = 0;
  endtask

  // Expected outputs for the current cycle, packed {sel, addr, pc_id, flushing}
  function automatic logic [66:0] model_out(input logic s, input logic b);
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        fl;
    fl = (!m_boot && m_flush_left > 0);
    addr = m_pc;
    if (m_boot || m_flush_left > 0 || b) sel = INST_NOP;
    else if (s) begin sel = INST_OLD; addr = m_pc_id; end
    else sel = INST_MEM;
    return {sel, addr, m_pc_id, fl};
  endfunction

  task automatic model_step(input logic s, input logic b, input logic [31:0] t);
    if (m_boot) begin
      m_pc_id = m_pc; m_pc = m_pc + 32'd4; m_boot = 1'b0;
    end else if (b) begin
      m_pc_id = m_pc; m_pc = t & 32'hFFFF_FFFC; m_flush_left = FLUSH_N;
    end else if (m_flush_left > 0) begin
      m_pc_id = m_pc;
      if (m_flush_left == 1) m_pc = m_pc + 32'd4;
      m_flush_left--;
    end else if (!s) begin
      m_pc_id = m_pc; m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [66:0] exp_q[$];

  task automatic compare_outputs(input string tag);
    logic [66:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: expected queue empty (t=%0t)", tag, $time);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".inst_sel"},   {30'd0, inst_sel}, {30'd0, e[66:65]});
    chk({tag, ".fetch_addr"}, fetch_addr, e[64:33]);
    chk({tag, ".pc_id"},      pc_id, e[32:1]);
    chk({tag, ".flushing"},   {31'd0, flushing}, {31'd0, e[0]});
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic drive(input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    stall = s; branch_taken = b; branch_target = t;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] pcid;
    logic        fl;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic setv(input int i, input logic s, input logic b, input logic [31:0] t,
                      input logic [1:0] sel, input logic [31:0] addr,
                      input logic [31:0] pcid, input logic fl);
    vecs[i].s = s; vecs[i].b = b; vecs[i].t = t;
    vecs[i].sel = sel; vecs[i].addr = addr; vecs[i].pcid = pcid; vecs[i].fl = fl;
  endtask

  task automatic fill_table();
    // boot then sequential fetch
    setv(0,  0, 0, 0,            INST_NOP, 32'h0,         32'h0,         0);
    setv(1,  0, 0, 0,            INST_MEM, 32'h4,         32'h0,         0);
    setv(2,  0, 0, 0,            INST_MEM, 32'h8,         32'h4,         0);
    setv(3,  0, 0, 0,            INST_MEM, 32'hC,         32'h8,         0);
    // 3-cycle stall at pc=16/pc_id=12
    setv(4,  1, 0, 0,            INST_OLD, 32'hC,         32'hC,         0);
    setv(5,  1, 0, 0,            INST_OLD, 32'hC,         32'hC,         0);
    setv(6,  1, 0, 0,            INST_OLD, 32'hC,         32'hC,         0);
    setv(7,  0, 0, 0,            INST_MEM, 32'h10,        32'hC,         0);
    setv(8,  0, 0, 0,            INST_MEM, 32'h14,        32'h10,        0);
    // taken branch to 0x103 (aligned to 0x100)
    setv(9,  0, 1, 32'h103,      INST_NOP, 32'h18,        32'h14,        0);
    setv(10, 0, 0, 0,            INST_NOP, 32'h100,       32'h18,        1);
    setv(11, 0, 0, 0,            INST_NOP, 32'h100,       32'h100,       1);
    setv(12, 0, 0, 0,            INST_MEM, 32'h104,       32'h100,       0);
    // branch with stall in same cycle, then re-branch mid-flush to 0x200
    setv(13, 1, 1, 32'h50,       INST_NOP, 32'h108,       32'h104,       0);
    setv(14, 0, 1, 32'h200,      INST_NOP, 32'h50,        32'h108,       1);
    setv(15, 0, 0, 0,            INST_NOP, 32'h200,       32'h50,        1);
    setv(16, 1, 0, 0,            INST_NOP, 32'h200,       32'h200,       1);
    setv(17, 0, 0, 0,            INST_MEM, 32'h204,       32'h200,       0);
    // branch near the top of the address space, then sequential wrap
    setv(18, 0, 1, 32'hFFFF_FFFB, INST_NOP, 32'h208,      32'h204,       0);
    setv(19, 0, 0, 0,            INST_NOP, 32'hFFFF_FFF8, 32'h208,       1);
    setv(20, 0, 0, 0,            INST_NOP, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1);
    setv(21, 0, 0, 0,            INST_MEM, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 0);
    setv(22, 0, 0, 0,            INST_MEM, 32'h0,         32'hFFFF_FFFC, 0);
    setv(23, 0, 0, 0,            INST_MEM, 32'h4,         32'h0,         0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        s, b;
    logic [31:0] t;
    fill_table();

    // reset state while rst is low
    repeat (2) @(posedge clk);
    #2;
    chk("rst.inst_sel",   {30'd0, inst_sel}, {30'd0, INST_NOP});
    chk("rst.fetch_addr", fetch_addr, RST_PC);
    chk("rst.pc_id",      pc_id, RST_PC);
    chk("rst.flushing",   {31'd0, flushing}, 32'd0);

    // release reset just after an edge so the next cycle is BOOT
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) drive(vecs[i].s, vecs[i].b, vecs[i].t);
      else begin stall = vecs[i].s; branch_taken = vecs[i].b; branch_target = vecs[i].t; end
      @(negedge clk);
      chk($sformatf("vec%0d.inst_sel", i),   {30'd0, inst_sel}, {30'd0, vecs[i].sel});
      chk($sformatf("vec%0d.fetch_addr", i), fetch_addr, vecs[i].addr);
      chk($sformatf("vec%0d.pc_id", i),      pc_id, vecs[i].pcid);
      chk($sformatf("vec%0d.flushing", i),   {31'd0, flushing}, {31'd0, vecs[i].fl});
    end

    // async reset in the middle of a flush, asserted between edges
    drive(0, 1, 32'h0000_0300);
    drive(0, 0, 32'h0);
    @(negedge clk);
    chk("pre_rst.flushing", {31'd0, flushing}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.inst_sel",   {30'd0, inst_sel}, {30'd0, INST_NOP});
    chk("midrst.fetch_addr", fetch_addr, RST_PC);
    chk("midrst.pc_id",      pc_id, RST_PC);
    chk("midrst.flushing",   {31'd0, flushing}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // boot sequence repeats after release, then random traffic
    model_reset();
    for (int i = 0; i < NRAND; i++) begin
      if (i < 4) begin
        s = 1'b0; b = 1'b0; t = 32'h0;
      end else begin
        s = ($urandom_range(0, 2) == 0);
        b = ($urandom_range(0, 7) == 0);
        t = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                         : $urandom;
      end
      if (i > 0) drive(s, b, t);
      else begin stall = s; branch_taken = b; branch_target = t; end
      exp_q.push_back(model_out(s, b));
      @(negedge clk);
      compare_outputs($sformatf("rnd%0d", i));
      model_step(s, b, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch controller that sits directly upstream of the instruction-management stage (inst_mgmt) in the rysyCore pipeline.
- Owns the program counter and drives the address of the synchronous instruction memory (1-cycle read latency).
- Tracks which PC the returned rdata belongs to.
- Generates inst_sel (INST_MEM / INST_OLD / INST_NOP) so inst_mgmt forwards, holds or squashes the fetched word on boot, stall and taken branch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
FLUSH_CYCLES, 2, number of cycles inst_sel is forced to INST_NOP after a taken branch; legal range 1..7.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  reset, asynchronous, active-low (rst=0 holds block in reset).
stall  input  1  hazard hold request from decode/execute.
branch_taken  input  1  redirect request (branch/jump resolved taken).
branch_target  input  32  redirect address.
fetch_addr  output  32  address to instruction memory (combinational).
pc_id  output  32  PC of the word currently on memory rdata.
inst_sel  output  2  selector for inst_mgmt (combinational from state/inputs).
flushing  output  1  high while state is FLUSH.

Behaviour:
- State registers: state {BOOT, RUN, FLUSH}, pc[31:0], pc_id[31:0], flush_cnt[2:0].
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, pc_id=RESET_PC, flush_cnt=0.
  - Outputs during reset: fetch_addr=RESET_PC, inst_sel=INST_NOP, flushing=0.
- BOOT: lasts exactly one cycle after rst rises.
  - Outputs: inst_sel=INST_NOP, fetch_addr=pc.
  - Next edge: pc<=pc+4, pc_id<=pc, state->RUN.
  - branch_taken and stall are ignored in BOOT.
- RUN, priority branch_taken > stall > normal:
  - normal: fetch_addr=pc, inst_sel=INST_MEM; next edge pc<=pc+4, pc_id<=pc.
  - stall=1: fetch_addr=pc_id (re-read so rdata stays valid), inst_sel=INST_OLD; pc and pc_id hold. When stall drops, the held word is forwarded with INST_MEM in that same cycle, so no instruction is lost or duplicated.
  - branch_taken=1: inst_sel=INST_NOP, fetch_addr=pc. Next edge: pc<={branch_target[31:2],2'b00}, pc_id<=pc, flush_cnt<=FLUSH_CYCLES-1, state->FLUSH.
- FLUSH:
  - Outputs: inst_sel=INST_NOP, flushing=1, fetch_addr=pc (the target).
  - flush_cnt>0: pc holds, pc_id<=pc, flush_cnt<=flush_cnt-1.
  - flush_cnt==0: pc<=pc+4, pc_id<=pc, state->RUN. The first RUN cycle therefore sees rdata=mem[target] with INST_MEM.
  - branch_taken in FLUSH reloads target and counter (same as in RUN); stall is ignored.
- Resulting NOP count: a taken branch yields exactly 1+FLUSH_CYCLES cycles of INST_NOP, counting the request cycle.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no overflow flag.
- Reset mid-operation (any state): immediate return to reset values; a flush in progress is abandoned.
- Unused inst_sel code 2'b11 is never driven.

Decomposition:
- Shared defines file (core_defines.vh), already included by inst_mgmt:
  - INST_MEM=2'd0, INST_OLD=2'd1, INST_NOP=2'd2.
  - NOP encoding 32'h00000013.
  - State encodings FETCH_BOOT/FETCH_RUN/FETCH_FLUSH.
- Single module; no sub-module warranted. The next-PC mux and FSM live together.
- Integration bench instantiates fetch_ctrl + 1-cycle ROM model + inst_mgmt.

Test Plan:
1. Reset release, RESET_PC=0, no stall/branch -> cycle0 inst_sel=NOP, fetch_addr=0; then fetch_addr 4,8,12..., pc_id 0,4,8..., inst_sel=MEM every cycle.
2. stall=1 for 3 cycles while pc=16, pc_id=12 -> fetch_addr=12, inst_sel=OLD for 3 cycles, pc/pc_id frozen; on release inst_sel=MEM with pc_id=12, then fetch_addr 16,20.
3. branch_taken=1, branch_target=32'h0000_0103, FLUSH_CYCLES=2 -> 3 NOP cycles, fetch_addr=0x100 during flush, flushing=1 for 2 cycles; then inst_sel=MEM with pc_id=0x100, fetch_addr=0x104.
4. branch_taken with stall=1 same cycle -> branch wins (INST_NOP, redirect); branch_taken again mid-FLUSH to 0x200 -> counter reloaded, first MEM word has pc_id=0x200.
5. pc=32'hFFFF_FFFC in RUN -> next fetch_addr=0, pc_id=FFFF_FFFC.
6. rst=0 asserted mid-FLUSH, between clock edges -> outputs immediately reset values (inst_sel=NOP, fetch_addr=RESET_PC); after release, test 1 sequence repeats.
